// File: rtl/lfsr_cipher_pkg.sv
// Shared definitions for the LFSR message cipher.
// Holds the encryptor state encoding, the fixed parameter addresses in data
// memory, the minimum prefix length, the padding character and the table of
// legal 7-bit tap patterns.
package lfsr_cipher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_PRE,
    ST_LD_TAP,
    ST_LD_INIT,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  localparam logic [7:0] ADDR_PRE    = 8'd61;
  localparam logic [7:0] ADDR_TAP    = 8'd62;
  localparam logic [7:0] ADDR_INIT   = 8'd63;
  localparam logic [3:0] PRE_MIN     = 4'd10;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int unsigned NUM_TAPS = 9;
  localparam logic [6:0] LEGAL_TAPS [NUM_TAPS] = '{
    7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
  };

endpackage

// File: rtl/lfsr7_step.sv
// One step of the 7-bit Fibonacci LFSR used by both cipher directions.
// Ports:
//   state_i : current LFSR state
//   taps_i  : tap mask; the feedback bit is the XOR of the tapped state bits
//   next_o  : state shifted left by one with the feedback bit in bit 0
module lfsr7_step (
  input  logic [6:0] state_i,
  input  logic [6:0] taps_i,
  output logic [6:0] next_o
);

  always_comb begin
    next_o = {state_i[5:0], ^(state_i & taps_i)};
  end

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Memory-mastering encryptor. Loads prefix length, tap pattern and seed from
// data memory, then streams N_BYTES ciphertext bytes to CT_BASE, two cycles
// per byte (read plaintext, write ciphertext).
// Ports:
//   Clk       : clock, all state on rising edge
//   Reset     : asynchronous active-low reset
//   Start     : level; high holds/returns the block to idle, low runs
//   Ack       : high while a completed run is being held
//   MemAddr   : data memory address
//   MemWrEn   : data memory write strobe
//   MemWrData : data memory write data
//   MemRdData : data memory read data, combinational from MemAddr
module lfsr_encrypt_engine
  import lfsr_cipher_pkg::*;
#(
  parameter int unsigned CT_BASE = 64,
  parameter int unsigned N_BYTES = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  output logic       MemWrEn,
  output logic [7:0] MemWrData,
  input  logic [7:0] MemRdData
);

  localparam logic [5:0] I_LAST    = 6'(N_BYTES - 1);
  localparam logic [7:0] CT_BASE_B = 8'(CT_BASE);

  state_e     state_q, state_d;
  logic [3:0] pre_q;
  logic [6:0] taps_q;
  logic [6:0] s_q;
  logic [5:0] i_q;
  logic [6:0] p_q;

  logic [5:0] pre6;
  logic       rd_live;
  logic [5:0] pt_idx;
  logic       last_byte;
  logic [6:0] s_next;
  logic [6:0] c_low;
  logic [3:0] pre_clamped;
  logic [6:0] seed_fixed;
  logic       rd_bit7_unused;

  // Plaintext bit 7 is never part of the cipher.
  assign rd_bit7_unused = MemRdData[7];

  assign pre6        = {2'b00, pre_q};
  assign rd_live     = (i_q >= pre6);
  assign pt_idx      = i_q - pre6;
  assign last_byte   = (i_q == I_LAST);
  assign c_low       = p_q ^ s_q;
  assign pre_clamped = (MemRdData[3:0] < PRE_MIN) ? PRE_MIN : MemRdData[3:0];
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_fixed  = (MemRdData[6:0] == 7'h00) ? 7'h01 : MemRdData[6:0];

  lfsr7_step u_step (
    .state_i (s_q),
    .taps_i  (taps_q),
    .next_o  (s_next)
  );

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Start high aborts any active state back to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (!Start) state_d = ST_LD_PRE;
      ST_LD_PRE:  state_d = Start ? ST_IDLE : ST_LD_TAP;
      ST_LD_TAP:  state_d = Start ? ST_IDLE : ST_LD_INIT;
      ST_LD_INIT: state_d = Start ? ST_IDLE : ST_RD;
      ST_RD:      state_d = Start ? ST_IDLE : ST_WR;
      ST_WR: begin
        if (Start)          state_d = ST_IDLE;
        else if (last_byte) state_d = ST_DONE;
        else                state_d = ST_RD;
      end
      ST_DONE:    if (Start) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pre_q  <= '0;
      taps_q <= '0;
      s_q    <= '0;
      i_q    <= '0;
      p_q    <= '0;
    end else begin
      unique case (state_q)
        ST_LD_PRE:  pre_q  <= pre_clamped;
        ST_LD_TAP:  taps_q <= MemRdData[6:0];
        ST_LD_INIT: begin
          s_q <= seed_fixed;
          i_q <= '0;
        end
        ST_RD:      p_q <= rd_live ? MemRdData[6:0] : ASCII_SPACE[6:0];
        ST_WR: begin
          s_q <= s_next;
          if (!last_byte) i_q <= i_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Output logic; memory port is driven purely from the current state.
  always_comb begin
    Ack       = 1'b0;
    MemAddr   = '0;
    MemWrEn   = 1'b0;
    MemWrData = '0;
    unique case (state_q)
      ST_LD_PRE:  MemAddr = ADDR_PRE;
      ST_LD_TAP:  MemAddr = ADDR_TAP;
      ST_LD_INIT: MemAddr = ADDR_INIT;
      ST_RD:      if (rd_live) MemAddr = {2'b00, pt_idx};
      ST_WR: begin
        MemAddr   = CT_BASE_B + {2'b00, i_q};
        MemWrEn   = 1'b1;
        MemWrData = {^c_low, c_low};
      end
      ST_DONE:    Ack = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
module tb_lfsr_encrypt_engine;
  import lfsr_cipher_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic [7:0] MemAddr;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic [7:0] MemRdData;

  lfsr_encrypt_engine #(.CT_BASE(64), .N_BYTES(64)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .MemRdData (MemRdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Read image (owned by the stimulus) and write capture (owned by memory process)
  logic [7:0]   dm  [0:255];
  logic [7:0]   ctm [0:255];
  logic [255:0] written;
  logic         clr_req;

  assign MemRdData = dm[MemAddr];

  always @(posedge Clk) begin
    if (clr_req) written <= '0;
    else if (MemWrEn) begin
      ctm[MemAddr]     <= MemWrData;
      written[MemAddr] <= 1'b1;
    end
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_seen = 0;

  // Monitor: every write the DUT presents is matched against the scoreboard
  always @(negedge Clk) begin
    if (Reset && MemWrEn) begin
      wr_t e;
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%0h", MemAddr, MemWrData);
      end else begin
        e = exp_q.pop_front();
        if (e.addr !== MemAddr || e.data !== MemWrData) begin
          errors++;
          $display("FAIL write got addr=%0h data=%0h expected addr=%0h data=%0h",
                   MemAddr, MemWrData, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: cipher from the rules, on the current memory image
  logic [7:0] exp_ct  [64];
  logic [7:0] base_ct [64];

  function automatic void model();
    int unsigned pre, taps, s, pt, c7;
    pre  = dm[61] & 15;
    if (pre < 10) pre = 10;
    taps = dm[62] & 8'h7f;
    s    = dm[63] & 8'h7f;
    if (s == 0) s = 1;
    for (int k = 0; k < 64; k++) begin
      pt = (k >= int'(pre)) ? int'(dm[k - pre]) : 32'h20;
      c7 = (pt ^ s) & 32'h7f;
      exp_ct[k] = 8'(((($countones(c7) & 1)) << 7) | c7);
      s = ((s << 1) | ($countones(s & taps) & 1)) & 32'h7f;
    end
  endfunction

  task automatic load(input logic [7:0] pre, input logic [7:0] tap,
                      input logic [7:0] init, input bit random_text);
    string msg;
    msg = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < 61; k++) begin
      if (random_text) dm[k] = 8'($urandom);
      else dm[k] = (k < msg.len()) ? 8'(msg[k]) : 8'h20;
    end
    dm[61] = pre;
    dm[62] = tap;
    dm[63] = init;
  endtask

  task automatic clear_capture();
    @(negedge Clk) clr_req = 1'b1;
    @(negedge Clk) clr_req = 1'b0;
  endtask

  task automatic push_expected();
    model();
    for (int k = 0; k < 64; k++) exp_q.push_back('{8'(64 + k), exp_ct[k]});
  endtask

  // Full run: drop Start, expect Ack exactly at E131, then release and see Ack drop
  task automatic run_full(input string name);
    int ack_at;
    int base_wr;
    clear_capture();
    push_expected();
    base_wr = wr_seen;
    ack_at  = -1;
    @(negedge Clk) Start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge Clk); #1;
      if (Ack) begin
        ack_at = n;
        break;
      end
    end
    chk({name, "_ack_edge"}, 32'(ack_at), 32'd131);
    chk({name, "_write_count"}, 32'(wr_seen - base_wr), 32'd64);
    chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    Start = 1'b1;
    @(posedge Clk); #1;
    chk({name, "_ack_drop"}, {31'd0, Ack}, 32'd0);
  endtask

  function automatic int diff_vs_base();
    int d = 0;
    for (int k = 0; k < 64; k++) if (ctm[64 + k] !== base_ct[k]) d++;
    return d;
  endfunction

  function automatic int written_in(input int lo, input int hi);
    int w = 0;
    for (int a = lo; a <= hi; a++) if (written[a]) w++;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_wr;
    int ack_seen;
    for (int a = 0; a < 256; a++) begin
      dm[a]  = 8'h00;
      ctm[a] = 8'h00;
    end
    clr_req = 1'b0;
    Start   = 1'b1;
    Reset   = 1'b0;
    #1;
    chk("reset_ack", {31'd0, Ack}, 32'd0);
    chk("reset_wren", {31'd0, MemWrEn}, 32'd0);
    chk("reset_addr", {24'd0, MemAddr}, 32'd0);
    @(negedge Clk); @(negedge Clk) Reset = 1'b1;

    // Base case
    load(8'd10, 8'h72, 8'h01, 1'b0);
    run_full("base");
    chk("base_ct64", {24'd0, ctm[64]}, 32'h21);
    chk("base_ct65", {24'd0, ctm[65]}, 32'h22);
    chk("base_ct66", {24'd0, ctm[66]}, 32'hA5);
    for (int k = 0; k < 64; k++) base_ct[k] = ctm[64 + k];

    // Zero seed behaves as seed 1
    load(8'd10, 8'h72, 8'h00, 1'b0);
    run_full("init0");
    chk("init0_vs_base", 32'(diff_vs_base()), 32'd0);

    // Prefix clamp and long prefix
    load(8'd3, 8'h72, 8'h01, 1'b0);
    run_full("pre3");
    chk("pre3_vs_base", 32'(diff_vs_base()), 32'd0);
    load(8'd15, 8'h72, 8'h01, 1'b0);
    run_full("pre15");

    // Random runs over the legal tap table
    for (int r = 0; r < 4; r++) begin
      load(8'($urandom), {1'b0, LEGAL_TAPS[$urandom_range(0, NUM_TAPS - 1)]},
           8'($urandom), 1'b1);
      run_full($sformatf("rand%0d", r));
    end

    // Reset during WR(20)
    load(8'd10, 8'h72, 8'h01, 1'b0);
    clear_capture();
    push_expected();
    base_wr = wr_seen;
    @(negedge Clk) Start = 1'b0;
    for (int n = 0; n < 45; n++) @(posedge Clk);
    #1 Reset = 1'b0;
    #1;
    chk("rst_mid_ack", {31'd0, Ack}, 32'd0);
    chk("rst_mid_wren", {31'd0, MemWrEn}, 32'd0);
    chk("rst_mid_addr", {24'd0, MemAddr}, 32'd0);
    exp_q.delete();
    Start = 1'b1;
    @(negedge Clk); @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    chk("rst_mid_writes", 32'(wr_seen - base_wr), 32'd20);
    chk("rst_mid_untouched", 32'(written_in(85, 127)), 32'd0);

    // Start abort during RD(5)
    clear_capture();
    push_expected();
    base_wr  = wr_seen;
    ack_seen = 0;
    @(negedge Clk) Start = 1'b0;
    for (int n = 0; n < 14; n++) @(posedge Clk);
    #1 Start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge Clk); #1;
      if (Ack) ack_seen++;
    end
    chk("abort_ack", 32'(ack_seen), 32'd0);
    chk("abort_idle_addr", {24'd0, MemAddr}, 32'd0);
    chk("abort_writes", 32'(wr_seen - base_wr), 32'd5);
    chk("abort_untouched", 32'(written_in(69, 127)), 32'd0);
    exp_q.delete();

    // Back-to-back runs; second run uses tap 48
    load(8'd10, 8'h72, 8'h01, 1'b0);
    run_full("b2b_first");
    dm[62] = 8'h48;
    run_full("b2b_second");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_encrypt_engine.md
# lfsr_encrypt_engine

Hardware encryptor for the message-cipher programs. It reads a plaintext string and its parameters from data memory, then applies the 7-bit LFSR stream cipher with parity prefix. It writes the 64-byte ciphertext back to data memory, where the decrypt program and bench consume it. The block is a memory-port master beside the processor core; it owns data memory for the duration of a run.

## Interface
- CT_BASE, default 64: first ciphertext address.
- N_BYTES, default 64: padded message length (bytes encrypted per run).
- Clk  in  1  single clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- Start  in  1  level request; high holds block idle, low lets a run begin.
- Ack  out  1  run complete; reset value 0.
- MemAddr  out  8  data memory address; reset value 0.
- MemWrEn  out  1  write strobe; reset value 0.
- MemWrData  out  8  write data; reset value 0.
- MemRdData  in  8  data memory read data, combinational from MemAddr in the same cycle.

## Operation
- Memory map:
  - DM[0..60]: plaintext, space-padded by the loader.
  - DM[61]: pre_length.
  - DM[62]: tap pattern.
  - DM[63]: LFSR init.
  - DM[CT_BASE..CT_BASE+63]: ciphertext output.
- States: IDLE, LD_PRE, LD_TAP, LD_INIT, RD, WR, DONE.
- IDLE: MemWrEn=0, Ack=0. If Start=0 on a rising edge, go to LD_PRE.
- LD_PRE: MemAddr=61. Latch pre = MemRdData[3:0]; if pre < 10, pre = 10.
- LD_TAP: MemAddr=62. Latch taps = MemRdData[6:0].
- LD_INIT: MemAddr=63. Latch s = MemRdData[6:0]; if s == 0, s = 7'h01. Clear index i = 0.
- RD(i):
  - If i >= pre, MemAddr = i − pre and latch p = MemRdData.
  - Otherwise p = 8'h20 (MemAddr still driven to 0, read ignored).
  - Since pre >= 10, i − pre ≤ 53, which is always inside 0..60.
- WR(i):
  - MemAddr = CT_BASE + i, MemWrEn = 1.
  - c[6:0] = p[6:0] ^ s; c[7] = ^c[6:0] (even parity over 7 bits).
  - Plaintext bit 7 is discarded.
- Advance at the end of WR:
  - s ← {s[5:0], ^(s & taps)}.
  - If i == N_BYTES−1, go to DONE; else i ← i+1 and go to RD.
- DONE: Ack=1, MemWrEn=0. Hold until Start=1, then go to IDLE (Ack drops the next cycle).
- Start=1 in any non-IDLE state other than DONE aborts synchronously to IDLE. Bytes already written remain; no further writes occur.
- Widths:
  - MemAddr arithmetic is 8-bit; CT_BASE+i must not exceed 255.
  - i is 6 bits wide, with a terminal-count compare (no wrap).

## Timing
- Let E0 be the edge leaving IDLE. States follow: LD_PRE at E0, LD_TAP at E1, LD_INIT at E2.
- RD(i) is entered at E3+2i; WR(i) at E4+2i.
- DONE (Ack=1) is entered at E131. A full run is 131 cycles from E0, 2 cycles per byte.
- Exactly one write per WR cycle; exactly 64 writes per complete run; no writes outside WR.
- Reset asserted at any time:
  - immediately forces Ack=0, MemWrEn=0, MemAddr=0, state IDLE;
  - an in-flight write is not performed once Reset is low.
- Reset release with Start=0 starts a run on the first subsequent edge.
- Start returned to 1 in DONE and then dropped again starts a fresh run. All parameters are reloaded; no state carries over.

## Structure
- Package lfsr_cipher_pkg holds:
  - the state enum;
  - constants ADDR_PRE=61, ADDR_TAP=62, ADDR_INIT=63, PRE_MIN=10, ASCII_SPACE=8'h20;
  - the nine legal tap patterns (60,48,78,72,6A,69,5C,7E,7B hex), for bench use.
- Sub-module lfsr7_step: combinational next = {s[5:0], ^(s & taps)}. Shared with the decrypt-side datapath.
- Engine top holds the FSM, pre/taps/s/i/p registers and the memory-port mux.

## Test plan
- Base case:
  - Stimulus: "Mr. Watson, come here. I want to see you." at DM[0..], DM[61]=10, DM[62]=8'h72, DM[63]=8'h01.
  - Response: DM[64]=8'h21, DM[65]=8'h22, DM[66]=8'hA5. All 64 bytes match the bench model; Ack at E131.
- Init-zero substitution: DM[63]=0, otherwise same as the base case. Ciphertext is identical to the base case.
- pre_length clamp: DM[61]=3. Same output as DM[61]=10; DM[61]=15 shifts the plaintext start to i=15.
- Reset mid-run: Reset low during WR(20). Ack=0 and MemWrEn=0 at once; DM[85..127] unchanged.
- Start abort: Start=1 during RD(5). Block returns to IDLE; DM[69..127] unwritten; Ack stays 0.
- Back-to-back runs: a second run with tap 8'h48 after Start toggles in DONE. Output matches the bench model for tap 48; Ack drops, then re-rises at E131.
